// File: rtl/mem_defs.sv
// rtl/mem_defs.sv - shared funct3 codes, FSM encoding and reset instruction for the memory port
package mem_defs;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] NOP_INSN = 32'h00000013;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;
endpackage

// File: rtl/ls_align.sv
// rtl/ls_align.sv - load sub-word extract/extend and store byte-lane merge
module ls_align
    import mem_defs::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] load_word,
    input  logic [31:0] base_word,
    input  logic [15:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        case (byte_off)
            2'd0:    sel_byte = load_word[7:0];
            2'd1:    sel_byte = load_word[15:8];
            2'd2:    sel_byte = load_word[23:16];
            default: sel_byte = load_word[31:24];
        endcase
        sel_half = byte_off[1] ? load_word[31:16] : load_word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data = {24'h0, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data = {16'h0, sel_half};
            F3_W:    load_data = load_word;
            default: load_data = 32'h0;
        endcase

        // Only SB/SH reach the merge; anything else passes the old word through
        merge_data = base_word;
        if (funct3 == F3_B) begin
            case (byte_off)
                2'd0:    merge_data[7:0]   = store_data[7:0];
                2'd1:    merge_data[15:8]  = store_data[7:0];
                2'd2:    merge_data[23:16] = store_data[7:0];
                default: merge_data[31:24] = store_data[7:0];
            endcase
        end else if (funct3 == F3_H) begin
            if (byte_off[1]) merge_data[31:16] = store_data;
            else             merge_data[15:0]  = store_data;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared DataMem front-end: data-first arbitration, load extend, SB/SH RMW
module mem_port_arbiter
    import mem_defs::*;
#(
    parameter int          ADDR_W   = 6,
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_INSN = mem_defs::NOP_INSN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [XLEN-1:0]   if_addr,
    output logic [XLEN-1:0]   if_rdata,
    output logic              if_ready,
    output logic              stall_if,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [2:0]        d_funct3,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    output logic [XLEN-1:0]   d_rdata,
    output logic              d_ready,
    output logic              access_fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);
    state_t          state, next_state;
    logic [XLEN-1:0] rmw_q, if_hold_q;
    logic [XLEN-1:0] load_data, merge_data;
    logic            d_req, illegal_f3, misaligned, fault;
    logic            rmw_capture, fetch_served;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^{if_addr[XLEN-1:ADDR_W+2], if_addr[1:0], d_addr[XLEN-1:ADDR_W+2]};

    ls_align u_align (
        .funct3     (d_funct3),
        .byte_off   (d_addr[1:0]),
        .load_word  (mem_rdata),
        .base_word  (rmw_q),
        .store_data (d_wdata[15:0]),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    assign d_req = d_read | d_write;

    always_comb begin
        if (d_write) illegal_f3 = !(d_funct3 inside {F3_B, F3_H, F3_W});
        else         illegal_f3 = !(d_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        misaligned = ((d_funct3[1:0] == 2'b10) && (d_addr[1:0] != 2'b00)) ||
                     ((d_funct3[1:0] == 2'b01) && d_addr[0]);
        fault = d_req && (illegal_f3 || misaligned);
    end

    always_comb begin
        next_state   = state;
        if_rdata     = if_hold_q;
        if_ready     = 1'b0;
        d_rdata      = '0;
        d_ready      = 1'b0;
        access_fault = 1'b0;
        mem_addr     = d_addr[ADDR_W+1:2];
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_wdata    = '0;
        rmw_capture  = 1'b0;
        fetch_served = 1'b0;

        case (state)
            IDLE: begin
                if (d_req) begin
                    if (fault) begin
                        access_fault = 1'b1;
                        d_ready      = 1'b1;
                    end else if (d_write) begin
                        if (d_funct3 == F3_W) begin
                            mem_write = 1'b1;
                            mem_wdata = d_wdata;
                            d_ready   = 1'b1;
                        end else begin
                            mem_read    = 1'b1;
                            rmw_capture = 1'b1;
                            next_state  = RMW_WR;
                        end
                    end else begin
                        mem_read = 1'b1;
                        d_ready  = 1'b1;
                        d_rdata  = load_data;
                    end
                end else if (if_req) begin
                    mem_read     = 1'b1;
                    mem_addr     = if_addr[ADDR_W+1:2];
                    if_ready     = 1'b1;
                    if_rdata     = mem_rdata;
                    fetch_served = 1'b1;
                end
            end
            RMW_WR: begin
                mem_write  = 1'b1;
                mem_wdata  = merge_data;
                d_ready    = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase

        // Reset silences the port combinationally so an in-flight RMW write never commits
        if (rst) begin
            next_state   = IDLE;
            if_rdata     = NOP_INSN;
            if_ready     = 1'b0;
            d_rdata      = '0;
            d_ready      = 1'b0;
            access_fault = 1'b0;
            mem_addr     = '0;
            mem_read     = 1'b0;
            mem_write    = 1'b0;
            mem_wdata    = '0;
            rmw_capture  = 1'b0;
            fetch_served = 1'b0;
        end
        stall_if = if_req && !if_ready && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rmw_q     <= '0;
            if_hold_q <= NOP_INSN;
        end else begin
            state <= next_state;
            if (rmw_capture)  rmw_q     <= mem_rdata;
            if (fetch_served) if_hold_q <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        load_mem;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        stall_if;
    logic        d_read;
    logic        d_write;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        access_fault;
    logic [5:0]  mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem [64];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rdata     (if_rdata),
        .if_ready     (if_ready),
        .stall_if     (stall_if),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_funct3     (d_funct3),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_ready      (d_ready),
        .access_fault (access_fault),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h00500093;
            mem[1] <= 32'hCAFEF00D;
            mem[2] <= 32'h00000003;
            mem[3] <= 32'h000080FF;
            mem[4] <= 32'h11223344;
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_d(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        d_read   = rd;
        d_write  = wr;
        d_funct3 = f3;
        d_addr   = a;
        d_wdata  = wd;
    endtask

    initial begin
        rst = 1'b1; load_mem = 1'b1;
        if_req = 1'b1; if_addr = 32'h8;
        set_d(1'b1, 1'b0, 3'b010, 32'h4, 32'h0);

        @(negedge clk); #2;
        chk("rst_if_rdata", if_rdata, 32'h00000013);
        chk("rst_if_ready", {31'h0, if_ready}, 32'h0);
        chk("rst_stall_if", {31'h0, stall_if}, 32'h0);
        chk("rst_d_ready", {31'h0, d_ready}, 32'h0);
        chk("rst_mem_read", {31'h0, mem_read}, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);

        // fetch from word 2
        @(negedge clk);
        rst = 1'b0; load_mem = 1'b0;
        set_d(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        #2;
        chk("fetch_mem_addr", {26'h0, mem_addr}, 32'd2);
        chk("fetch_mem_read", {31'h0, mem_read}, 32'h1);
        chk("fetch_if_ready", {31'h0, if_ready}, 32'h1);
        chk("fetch_if_rdata", if_rdata, 32'h3);
        chk("fetch_stall_if", {31'h0, stall_if}, 32'h0);

        // load extraction from mem[3] = 0x000080FF
        @(negedge clk); if_req = 1'b0;
        set_d(1'b1, 1'b0, 3'b000, 32'hC, 32'h0); #2;
        chk("lb_c", d_rdata, 32'hFFFFFFFF);
        chk("lb_c_ready", {31'h0, d_ready}, 32'h1);
        chk("lb_c_fault", {31'h0, access_fault}, 32'h0);
        @(negedge clk); set_d(1'b1, 1'b0, 3'b100, 32'hD, 32'h0); #2;
        chk("lbu_d", d_rdata, 32'h00000080);
        @(negedge clk); set_d(1'b1, 1'b0, 3'b001, 32'hC, 32'h0); #2;
        chk("lh_c", d_rdata, 32'hFFFF80FF);
        @(negedge clk); set_d(1'b1, 1'b0, 3'b101, 32'hC, 32'h0); #2;
        chk("lhu_c", d_rdata, 32'h000080FF);
        @(negedge clk); set_d(1'b1, 1'b0, 3'b010, 32'h10C, 32'h0); #2;
        chk("lw_wrap", d_rdata, 32'h000080FF);

        // SB @0x11 with a competing fetch
        @(negedge clk); if_req = 1'b1; if_addr = 32'h0;
        set_d(1'b0, 1'b1, 3'b000, 32'h11, 32'h123456AA); #2;
        chk("sb_c1_ready", {31'h0, d_ready}, 32'h0);
        chk("sb_c1_mem_read", {31'h0, mem_read}, 32'h1);
        chk("sb_c1_mem_write", {31'h0, mem_write}, 32'h0);
        chk("sb_c1_stall", {31'h0, stall_if}, 32'h1);
        chk("sb_c1_if_rdata", if_rdata, 32'h3);
        @(negedge clk); #2;
        chk("sb_c2_mem_write", {31'h0, mem_write}, 32'h1);
        chk("sb_c2_mem_read", {31'h0, mem_read}, 32'h0);
        chk("sb_c2_mem_addr", {26'h0, mem_addr}, 32'd4);
        chk("sb_c2_wdata", mem_wdata, 32'h1122AA44);
        chk("sb_c2_ready", {31'h0, d_ready}, 32'h1);
        chk("sb_c2_stall", {31'h0, stall_if}, 32'h1);
        chk("sb_c2_if_rdata", if_rdata, 32'h3);

        // fetch@0 vs LW@4: data first, fetch next cycle
        @(negedge clk); set_d(1'b1, 1'b0, 3'b010, 32'h4, 32'h0); #2;
        chk("conf_d_rdata", d_rdata, 32'hCAFEF00D);
        chk("conf_if_ready", {31'h0, if_ready}, 32'h0);
        chk("conf_stall", {31'h0, stall_if}, 32'h1);
        @(negedge clk); set_d(1'b0, 1'b0, 3'b010, 32'h0, 32'h0); #2;
        chk("conf_fetch_ready", {31'h0, if_ready}, 32'h1);
        chk("conf_fetch_rdata", if_rdata, 32'h00500093);

        @(negedge clk); if_req = 1'b0;
        set_d(1'b1, 1'b0, 3'b010, 32'h10, 32'h0); #2;
        chk("sb_readback", d_rdata, 32'h1122AA44);

        // SH into upper half of word 3
        @(negedge clk); set_d(1'b0, 1'b1, 3'b001, 32'hE, 32'h0000BEEF); #2;
        chk("sh_c1_ready", {31'h0, d_ready}, 32'h0);
        @(negedge clk); #2;
        chk("sh_c2_wdata", mem_wdata, 32'hBEEF80FF);

        // faults
        @(negedge clk); set_d(1'b0, 1'b1, 3'b010, 32'h6, 32'hFFFFFFFF); #2;
        chk("sw6_fault", {31'h0, access_fault}, 32'h1);
        chk("sw6_ready", {31'h0, d_ready}, 32'h1);
        chk("sw6_mem_write", {31'h0, mem_write}, 32'h0);
        @(negedge clk); set_d(1'b1, 1'b0, 3'b010, 32'h4, 32'h0); #2;
        chk("sw6_mem1_kept", d_rdata, 32'hCAFEF00D);
        chk("lw_ok_fault", {31'h0, access_fault}, 32'h0);
        @(negedge clk); set_d(1'b1, 1'b0, 3'b001, 32'h3, 32'h0); #2;
        chk("lh3_fault", {31'h0, access_fault}, 32'h1);
        chk("lh3_ready", {31'h0, d_ready}, 32'h1);
        chk("lh3_rdata", d_rdata, 32'h0);
        @(negedge clk); set_d(1'b1, 1'b0, 3'b011, 32'h4, 32'h0); #2;
        chk("ld_f3_fault", {31'h0, access_fault}, 32'h1);
        @(negedge clk); set_d(1'b0, 1'b1, 3'b100, 32'h4, 32'h0); #2;
        chk("st_f3_fault", {31'h0, access_fault}, 32'h1);
        chk("st_f3_mem_write", {31'h0, mem_write}, 32'h0);

        // read and write together: write wins
        @(negedge clk); set_d(1'b1, 1'b1, 3'b010, 32'h14, 32'h5A5A0F0F); #2;
        chk("rw_mem_write", {31'h0, mem_write}, 32'h1);
        chk("rw_mem_read", {31'h0, mem_read}, 32'h0);
        @(negedge clk); set_d(1'b1, 1'b0, 3'b010, 32'h14, 32'h0); #2;
        chk("rw_readback", d_rdata, 32'h5A5A0F0F);

        // reset during RMW_WR drops the write
        @(negedge clk); set_d(1'b0, 1'b1, 3'b000, 32'h10, 32'h00000055); #2;
        chk("rstrmw_c1_ready", {31'h0, d_ready}, 32'h0);
        @(negedge clk); rst = 1'b1; #2;
        chk("rstrmw_mem_write", {31'h0, mem_write}, 32'h0);
        chk("rstrmw_if_rdata", if_rdata, 32'h00000013);
        @(negedge clk); rst = 1'b0; if_req = 1'b1; if_addr = 32'h8;
        set_d(1'b1, 1'b0, 3'b010, 32'h10, 32'h0); #2;
        chk("rstrmw_idle_ready", {31'h0, d_ready}, 32'h1);
        chk("rstrmw_mem_kept", d_rdata, 32'h1122AA44);
        chk("rstrmw_hold_nop", if_rdata, 32'h00000013);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
